// File: rtl/mem_arbiter.sv
// Three-way SDRAM word-port arbiter: video > disk > CPU, with a CPU starvation
// override that lets a long-waiting CPU request outrank disk (never video).
//
// state | meaning
// IDLE  | sample requests, latch the winner onto mem_*, raise mem_req
// BUSY  | hold mem_* stable until mem_ready, capture read data
// DONE  | owner's ack high for one cycle, no arbitration, owner back to 0
module mem_arbiter #(
  parameter int ADDR_W = 25,
  parameter int STARVE = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [15:0]       vid_dout,
  output logic              vid_ack,
  input  logic              dsk_req,
  input  logic              dsk_we,
  input  logic [ADDR_W-1:0] dsk_addr,
  input  logic [15:0]       dsk_din,
  output logic [15:0]       dsk_dout,
  output logic              dsk_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_wtbt,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_DSK  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                vid_ack_q, vid_ack_d;
  logic                dsk_ack_q, dsk_ack_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [15:0]         vid_dout_q, vid_dout_d;
  logic [15:0]         dsk_dout_q, dsk_dout_d;
  logic [15:0]         cpu_dout_q, cpu_dout_d;
  logic [CW-1:0]       cpu_wait_q, cpu_wait_d;
  logic [1:0]          win;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      vid_ack_q   <= 1'b0;
      dsk_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_dout_q  <= 16'h0000;
      dsk_dout_q  <= 16'h0000;
      cpu_dout_q  <= 16'h0000;
      cpu_wait_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vid_ack_q   <= vid_ack_d;
      dsk_ack_q   <= dsk_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_dout_q  <= vid_dout_d;
      dsk_dout_q  <= dsk_dout_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_wait_q  <= cpu_wait_d;
    end
  end

  // Starved CPU only jumps ahead of disk; video still wins outright.
  always_comb begin
    win = OWN_NONE;
    if (vid_req)
      win = OWN_VID;
    else if (dsk_req && !(cpu_req && (cpu_wait_q >= STARVE_C)))
      win = OWN_DSK;
    else if (cpu_req)
      win = OWN_CPU;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    vid_ack_d   = 1'b0;
    dsk_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_dout_d  = vid_dout_q;
    dsk_dout_d  = dsk_dout_q;
    cpu_dout_d  = cpu_dout_q;

    case (state_q)
      IDLE: begin
        if (win != OWN_NONE) begin
          owner_d   = win;
          mem_req_d = 1'b1;
          state_d   = BUSY;
          case (win)
            OWN_VID: begin
              mem_we_d    = 1'b0;
              mem_be_d    = 2'b11;
              mem_addr_d  = vid_addr;
              mem_wdata_d = 16'h0000;
            end
            OWN_DSK: begin
              mem_we_d    = dsk_we;
              mem_be_d    = 2'b11;
              mem_addr_d  = dsk_addr;
              mem_wdata_d = dsk_din;
            end
            default: begin
              mem_we_d    = cpu_we;
              mem_be_d    = cpu_we ? cpu_wtbt : 2'b11;
              mem_addr_d  = cpu_addr;
              mem_wdata_d = cpu_din;
            end
          endcase
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          case (owner_q)
            OWN_VID: begin
              vid_ack_d = 1'b1;
              if (!mem_we_q) vid_dout_d = mem_rdata;
            end
            OWN_DSK: begin
              dsk_ack_d = 1'b1;
              if (!mem_we_q) dsk_dout_d = mem_rdata;
            end
            OWN_CPU: begin
              cpu_ack_d = 1'b1;
              if (!mem_we_q) cpu_dout_d = mem_rdata;
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        owner_d   = OWN_NONE;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Wait counter stays at zero while the CPU owns the port.
  always_comb begin
    cpu_wait_d = cpu_wait_q;
    if (!cpu_req)
      cpu_wait_d = '0;
    else if ((state_q == IDLE) && (win == OWN_CPU))
      cpu_wait_d = '0;
    else if (owner_q == OWN_CPU)
      cpu_wait_d = '0;
    else if (cpu_wait_q < STARVE_C)
      cpu_wait_d = cpu_wait_q + 1'b1;
  end

  assign owner     = owner_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign vid_ack   = vid_ack_q;
  assign dsk_ack   = dsk_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_dout  = vid_dout_q;
  assign dsk_dout  = dsk_dout_q;
  assign cpu_dout  = cpu_dout_q;

endmodule
